// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector, the
// Jump/Branch encodings also driven by the control decoder, and target helpers.
package inst_fetch_pkg;

   localparam int unsigned XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   // Encodings are shared with the central decoder; value 3 is reserved and acts as "none"
   localparam logic [1:0] JUMP_NONE  = 2'd0;
   localparam logic [1:0] JUMP_IMM26 = 2'd1;
   localparam logic [1:0] JUMP_REG   = 2'd2;

   localparam logic [1:0] BR_NONE = 2'd0;
   localparam logic [1:0] BR_BEQ  = 2'd1;
   localparam logic [1:0] BR_BNE  = 2'd2;

   function automatic logic [31:0] branchOffset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

   function automatic logic [31:0] jumpTarget(input logic [3:0] region, input logic [25:0] index);
      return {region, index, 2'b00};
   endfunction

   function automatic logic [31:0] regTarget(input logic [31:0] rsData);
      return {rsData[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_npc.sv
// Combinational next-PC selection: register jump, immediate jump, taken
// branch or fall-through, plus a flag for a misaligned register target.
module npc_calc
   import inst_fetch_pkg::*;
(
   input  logic [31:0] i_pcPlus4,
   input  logic [25:0] i_instIndex,
   input  logic [1:0]  i_jump,
   input  logic [1:0]  i_branch,
   input  logic        i_zero,
   input  logic [31:0] i_rsData,
   output logic [31:0] o_nextPc,
   output logic        o_misalign
);

   logic        w_takeBranch;
   logic [31:0] w_branchTarget;

   assign w_takeBranch   = ((i_branch == BR_BEQ) &&  i_zero) ||
                           ((i_branch == BR_BNE) && !i_zero);
   assign w_branchTarget = i_pcPlus4 + branchOffset(i_instIndex[15:0]);

   // Jump decides first; the reserved jump code falls through to branch handling
   always_comb begin
      o_nextPc   = i_pcPlus4;
      o_misalign = 1'b0;
      case (i_jump)
         JUMP_IMM26: o_nextPc = jumpTarget(i_pcPlus4[31:28], i_instIndex);
         JUMP_REG: begin
            o_nextPc   = regTarget(i_rsData);
            o_misalign = |i_rsData[1:0];
         end
         default: begin
            if (w_takeBranch) begin
               o_nextPc = w_branchTarget;
            end
         end
      endcase
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: req/ack fetch from instruction memory, holds the
// instruction for decode until retired, then advances the PC.
module inst_fetch
   import inst_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic [1:0]  Jump,
   input  logic [1:0]  Branch,
   input  logic        zero,
   input  logic [31:0] rs_data,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err,
   output logic [31:0] inst_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_instCount;
   logic        r_fetchErr;
   logic [31:0] w_pcPlus4;
   logic [31:0] w_nextPc;
   logic        w_misalign;
   logic        w_capture;
   logic        w_retire;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    w_nextState = REQ;
         REQ:     if (imem_ack)   w_nextState = HOLD;
         HOLD:    if (inst_ready) w_nextState = REQ;
         default: w_nextState = IDLE;
      endcase
   end

   // Handshake outputs come from state alone, so no input reaches an output combinationally
   always_comb begin
      imem_req   = 1'b0;
      inst_valid = 1'b0;
      case (r_state)
         REQ:     imem_req   = 1'b1;
         HOLD:    inst_valid = 1'b1;
         default: ;
      endcase
   end

   assign w_capture = (r_state == REQ)  && imem_ack;
   assign w_retire  = (r_state == HOLD) && inst_ready;
   assign w_pcPlus4 = r_pc + 32'd4;

   npc_calc u_npc (
      .i_pcPlus4   (w_pcPlus4),
      .i_instIndex (r_inst[25:0]),
      .i_jump      (Jump),
      .i_branch    (Branch),
      .i_zero      (zero),
      .i_rsData    (rs_data),
      .o_nextPc    (w_nextPc),
      .o_misalign  (w_misalign)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_inst <= '0;
      end else if (w_capture) begin
         r_inst <= imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc        <= RESET_PC;
         r_instCount <= '0;
      end else if (w_retire) begin
         r_pc        <= w_nextPc;
         r_instCount <= r_instCount + 32'd1;
      end
   end

   // Sticky until reset so software can poll it long after the offending jr/jalr
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_fetchErr <= 1'b0;
      end else if (w_retire && w_misalign) begin
         r_fetchErr <= 1'b1;
      end
   end

   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign pc_plus4   = w_pcPlus4;
   assign inst       = r_inst;
   assign fetch_err  = r_fetchErr;
   assign inst_count = r_instCount;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized
// traffic compared against an arithmetic reference of the next-PC rules.
module tb_inst_fetch;

   logic        clk;
   logic        rstn;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [1:0]  Jump;
   logic [1:0]  Branch;
   logic        zero;
   logic [31:0] rs_data;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_err;
   logic [31:0] inst_count;

   int          assertCount;
   int          failCount;
   logic [31:0] modelPc;
   logic [31:0] modelInst;
   logic [31:0] modelCount;
   logic        modelErr;

   inst_fetch dut (
      .clk        (clk),
      .rstn       (rstn),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .Jump       (Jump),
      .Branch     (Branch),
      .zero       (zero),
      .rs_data    (rs_data),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .fetch_err  (fetch_err),
      .inst_count (inst_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference next-PC from the instruction-set rules, using plain arithmetic
   function automatic logic [31:0] refNextPc(input logic [31:0] curPc, input logic [31:0] word,
                                             input logic [1:0] j, input logic [1:0] b,
                                             input logic z, input logic [31:0] rs);
      logic [31:0] link;
      int          offset;
      link = curPc + 32'd4;
      if (j == 2'd1) return (link & 32'hF000_0000) | ({6'd0, word[25:0]} * 32'd4);
      if (j == 2'd2) return rs & 32'hFFFF_FFFC;
      if ((b == 2'd1 && z) || (b == 2'd2 && !z)) begin
         offset = $signed(word[15:0]);
         return link + 32'(offset * 4);
      end
      return link;
   endfunction

   task automatic checkReset(input string tag);
      checkOutput({tag, "_req"},   imem_req,   0);
      checkOutput({tag, "_valid"}, inst_valid, 0);
      checkOutput({tag, "_pc"},    pc,         32'h0000_3000);
      checkOutput({tag, "_addr"},  imem_addr,  32'h0000_3000);
      checkOutput({tag, "_inst"},  inst,       0);
      checkOutput({tag, "_err"},   fetch_err,  0);
      checkOutput({tag, "_count"}, inst_count, 0);
   endtask

   // Asserts reset between edges, then releases so the next edge enters REQ
   task automatic doReset(input string tag);
      rstn     = 1'b0;
      imem_ack = 1'b1;
      #2;
      checkReset(tag);
      modelPc    = 32'h0000_3000;
      modelInst  = 32'h0;
      modelCount = 32'h0;
      modelErr   = 1'b0;
      imem_ack   = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      #1;
      checkOutput({tag, "_idleReq"}, imem_req, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic fetchInst(input logic [31:0] word, input int ackDelay);
      for (int k = 0; k < ackDelay; k++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         inst_ready = 1'($urandom);
         checkOutput("ackWaitReq",   imem_req,   1);
         checkOutput("ackWaitAddr",  imem_addr,  modelPc);
         checkOutput("ackWaitValid", inst_valid, 0);
         @(posedge clk);
         #1;
      end
      checkOutput("req",  imem_req,  1);
      checkOutput("addr", imem_addr, modelPc);
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(posedge clk);
      #1;
      imem_ack   = 1'b0;
      inst_ready = 1'b0;
      imem_rdata = ~word;
      modelInst  = word;
      checkOutput("holdValid",  inst_valid, 1);
      checkOutput("holdInst",   inst,       word);
      checkOutput("holdReqLow", imem_req,   0);
      checkOutput("holdPc",     pc,         modelPc);
      checkOutput("holdPlus4",  pc_plus4,   modelPc + 32'd4);
   endtask

   task automatic retireInst(input int readyDelay, input logic [1:0] j, input logic [1:0] b,
                             input logic z, input logic [31:0] rs);
      for (int k = 0; k < readyDelay; k++) begin
         inst_ready = 1'b0;
         imem_ack   = 1'b1;
         imem_rdata = $urandom;
         Jump       = 2'($urandom);
         Branch     = 2'($urandom);
         zero       = 1'($urandom);
         rs_data    = $urandom;
         @(posedge clk);
         #1;
         checkOutput("readyWaitValid", inst_valid, 1);
         checkOutput("readyWaitInst",  inst,       modelInst);
      end
      imem_ack   = 1'b0;
      inst_ready = 1'b1;
      Jump       = j;
      Branch     = b;
      zero       = z;
      rs_data    = rs;
      @(posedge clk);
      #1;
      inst_ready = 1'b0;
      Jump       = 2'($urandom);
      Branch     = 2'($urandom);
      zero       = 1'($urandom);
      rs_data    = $urandom;
      if (j == 2'd2 && rs[1:0] != 2'b00) modelErr = 1'b1;
      modelPc    = refNextPc(modelPc, modelInst, j, b, z, rs);
      modelCount = modelCount + 32'd1;
      checkOutput("retireCount",  inst_count, modelCount);
      checkOutput("retireErr",    fetch_err,  modelErr);
      checkOutput("retireValid",  inst_valid, 0);
      checkOutput("nextReq",      imem_req,   1);
      checkOutput("nextAddr",     imem_addr,  modelPc);
   endtask

   task automatic applyStimulus(input logic [31:0] word, input int ackDelay, input int readyDelay,
                                input logic [1:0] j, input logic [1:0] b, input logic z,
                                input logic [31:0] rs);
      fetchInst(word, ackDelay);
      retireInst(readyDelay, j, b, z, rs);
   endtask

   initial begin
      logic [31:0] word;
      logic [31:0] rs;
      assertCount = 0;
      failCount   = 0;
      rstn        = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      inst_ready  = 1'b0;
      Jump        = 2'd0;
      Branch      = 2'd0;
      zero        = 1'b0;
      rs_data     = 32'h0;
      #12;
      $display("[TB] power-on reset");
      doReset("por");

      $display("[TB] back-to-back sequential fetches");
      applyStimulus(32'h0000_0000, 0, 0, 2'd0, 2'd0, 1'b0, 32'h0);
      applyStimulus(32'h2108_0001, 0, 0, 2'd0, 2'd0, 1'b0, 32'h0);
      applyStimulus(32'h0000_0000, 0, 0, 2'd0, 2'd0, 1'b0, 32'h0);
      checkOutput("seqCount3", inst_count, 32'd3);
      checkOutput("seqPc",     pc,         32'h0000_300C);

      $display("[TB] delayed ack");
      doReset("rstAck");
      applyStimulus(32'h0000_0000, 3, 2, 2'd0, 2'd0, 1'b0, 32'h0);

      $display("[TB] beq/bne with imm16 0xFFFF");
      doReset("rstBr");
      applyStimulus(32'h1000_FFFF, 0, 0, 2'd1, 2'd0, 1'b0, 32'h0);
      doReset("rstBr1");
      applyStimulus(32'h1000_FFFF, 0, 0, 2'd0, 2'd1, 1'b1, 32'h0);
      checkOutput("beqTaken", imem_addr, 32'h0000_3000);
      applyStimulus(32'h1000_FFFF, 0, 0, 2'd0, 2'd1, 1'b0, 32'h0);
      checkOutput("beqNotTaken", imem_addr, 32'h0000_3004);
      doReset("rstBne");
      applyStimulus(32'h1400_FFFF, 1, 1, 2'd0, 2'd2, 1'b0, 32'h0);
      checkOutput("bneTaken", imem_addr, 32'h0000_3000);

      $display("[TB] imm26 jump and priority over branch");
      doReset("rstJ");
      applyStimulus(32'h0800_0C10, 0, 0, 2'd1, 2'd0, 1'b0, 32'h0);
      checkOutput("jumpImm", imem_addr, 32'h0000_3040);
      doReset("rstJb");
      applyStimulus(32'h0800_0C10, 0, 0, 2'd1, 2'd1, 1'b1, 32'h0);
      checkOutput("jumpWins", imem_addr, 32'h0000_3040);

      $display("[TB] misaligned register jump");
      doReset("rstJr");
      applyStimulus(32'h0060_0008, 0, 0, 2'd2, 2'd0, 1'b0, 32'h0000_3102);
      checkOutput("jrTarget", imem_addr, 32'h0000_3100);
      checkOutput("jrErr",    fetch_err, 1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus($urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                       2'd0, 2'($urandom), 1'($urandom), $urandom);
      end
      checkOutput("errSticky", fetch_err, 1);

      $display("[TB] PC wrap at top of address space");
      doReset("rstWrap");
      applyStimulus(32'h0000_0000, 0, 0, 2'd2, 2'd0, 1'b0, 32'hFFFF_FFFC);
      applyStimulus(32'h0000_0000, 0, 0, 2'd0, 2'd0, 1'b0, 32'h0);
      checkOutput("wrapAddr", imem_addr, 32'h0000_0000);

      $display("[TB] reset during HOLD");
      doReset("rstPreHold");
      applyStimulus(32'h0800_0C10, 0, 0, 2'd1, 2'd0, 1'b0, 32'h0);
      fetchInst(32'hDEAD_BEEF, 1);
      checkOutput("preResetPc", pc, 32'h0000_3040);
      doReset("midHold");
      checkOutput("postResetAddr", imem_addr, 32'h0000_3000);
      checkOutput("postResetReq",  imem_req,  1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 40; i++) begin
         word = $urandom;
         rs   = $urandom;
         applyStimulus(word, $urandom_range(0, 2), $urandom_range(0, 2),
                       2'($urandom), 2'($urandom), 1'($urandom), rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
